// File: rtl/display_pkg.sv
// Shared definitions for the hex display renderer: glyph geometry, font ROM,
// FSM state encoding and framebuffer indexing helpers.
package display_pkg;

    localparam int unsigned GLYPH_W    = 3;
    localparam int unsigned GLYPH_H    = 5;
    localparam int unsigned GLYPH_BITS = GLYPH_W * GLYPH_H;

    // Row 0 of a glyph is bits [14:12]; the MSB of each triple lands on the highest column.
    localparam logic [GLYPH_BITS-1:0] HEX_FONT [16] = '{
        15'h7B6F, 15'h2C97, 15'h73E7, 15'h73CF,
        15'h5BC9, 15'h79CF, 15'h79EF, 15'h7249,
        15'h7BEF, 15'h7BCF, 15'h7BED, 15'h6BAE,
        15'h7927, 15'h6B6E, 15'h79E7, 15'h79E4
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DRAW,
        ST_COMMIT
    } state_e;

    function automatic int unsigned fb_index(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned width);
        return row * width + col;
    endfunction

    function automatic logic [GLYPH_W-1:0] glyph_row(input logic [GLYPH_BITS-1:0] glyph,
                                                     input logic [2:0]            r);
        logic [GLYPH_W-1:0] bits;
        case (r)
            3'd0:    bits = glyph[14:12];
            3'd1:    bits = glyph[11:9];
            3'd2:    bits = glyph[8:6];
            3'd3:    bits = glyph[5:3];
            3'd4:    bits = glyph[2:0];
            default: bits = '0;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/hex_glyph.sv
// Combinational font lookup: one hex nibble to its 15-bit 3x5 glyph.
module hex_glyph
    import display_pkg::*;
(
    input  logic [3:0]            nibble_i,
    output logic [GLYPH_BITS-1:0] glyph_c_o
);

    assign glyph_c_o = HEX_FONT[nibble_i];

endmodule

// File: rtl/display_renderer.sv
// Sequential hex-byte renderer: clears a back buffer, draws enabled channels
// row by row with clipping and OR-merge, then commits the frame in one cycle.
module display_renderer
    import display_pkg::*;
#(
    parameter int unsigned WIDTH     = 40,
    parameter int unsigned HEIGHT    = 30,
    parameter int unsigned CHANNELS  = 3,
    parameter int unsigned X0        = 6,
    parameter int unsigned X_PITCH   = 10,
    parameter int unsigned DIGIT_GAP = 5,
    parameter int unsigned Y_BIAS    = 2,
    parameter int unsigned YW        = $clog2(HEIGHT)
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [CHANNELS*8-1:0]     letters_i,
    input  logic [CHANNELS*YW-1:0]    ypos_i,
    input  logic [CHANNELS-1:0]       ch_en_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [WIDTH*HEIGHT-1:0]   framebuffer_o
);

    localparam int unsigned NPIX = WIDTH * HEIGHT;
    localparam int unsigned CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    generate
        if (X0 + (CHANNELS - 1) * X_PITCH + DIGIT_GAP + 2 >= WIDTH) begin : g_bad_geometry
            $error("display_renderer: glyph columns exceed WIDTH");
        end
    endgenerate

    state_e                   state_q,   state_d;
    logic [YW-1:0]            row_q,     row_d;
    logic [CW-1:0]            ch_q,      ch_d;
    logic [2:0]               gr_q,      gr_d;
    logic [CHANNELS*8-1:0]    letters_q, letters_d;
    logic [CHANNELS*YW-1:0]   ypos_q,    ypos_d;
    logic [CHANNELS-1:0]      en_q,      en_d;
    logic [NPIX-1:0]          bb_q,      bb_d;
    logic [NPIX-1:0]          fb_q,      fb_d;
    logic                     busy_q,    busy_d;
    logic                     done_q,    done_d;

    logic [7:0]               cur_byte_c;
    logic [YW-1:0]            cur_ypos_c;
    logic                     cur_en_c;
    logic [GLYPH_BITS-1:0]    glyph_hi_c;
    logic [GLYPH_BITS-1:0]    glyph_lo_c;
    int unsigned              draw_row_c;
    int unsigned              pix_l_c;
    int unsigned              pix_r_c;

    // Mux the latched inputs of the channel currently being drawn.
    always_comb begin
        cur_byte_c = '0;
        cur_ypos_c = '0;
        cur_en_c   = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_q == CW'(c)) begin
                cur_byte_c = letters_q[8*c +: 8];
                cur_ypos_c = ypos_q[YW*c +: YW];
                cur_en_c   = en_q[c];
            end
        end
    end

    hex_glyph u_glyph_hi (
        .nibble_i  (cur_byte_c[7:4]),
        .glyph_c_o (glyph_hi_c)
    );

    hex_glyph u_glyph_lo (
        .nibble_i  (cur_byte_c[3:0]),
        .glyph_c_o (glyph_lo_c)
    );

    // Target row and the base pixel of each triple for the current draw step.
    always_comb begin
        draw_row_c = 32'(cur_ypos_c) + Y_BIAS + 32'(gr_q);
        pix_l_c    = fb_index(draw_row_c, X0 + 32'(ch_q) * X_PITCH, WIDTH);
        pix_r_c    = pix_l_c + DIGIT_GAP;
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        ch_d      = ch_q;
        gr_d      = gr_q;
        letters_d = letters_q;
        ypos_d    = ypos_q;
        en_d      = en_q;
        bb_d      = bb_q;
        fb_d      = fb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    letters_d = letters_i;
                    ypos_d    = ypos_i;
                    en_d      = ch_en_i;
                    row_d     = '0;
                    ch_d      = '0;
                    gr_d      = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                bb_d[fb_index(32'(row_q), 0, WIDTH) +: WIDTH] = '0;
                if (row_q == YW'(HEIGHT - 1)) begin
                    state_d = ST_DRAW;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end

            ST_DRAW: begin
                // Rows below the framebuffer are dropped rather than wrapped.
                if (cur_en_c && (draw_row_c < HEIGHT)) begin
                    bb_d[pix_l_c +: GLYPH_W] = bb_d[pix_l_c +: GLYPH_W] | glyph_row(glyph_hi_c, gr_q);
                    bb_d[pix_r_c +: GLYPH_W] = bb_d[pix_r_c +: GLYPH_W] | glyph_row(glyph_lo_c, gr_q);
                end
                if (gr_q == 3'(GLYPH_H - 1)) begin
                    gr_d = '0;
                    if (ch_q == CW'(CHANNELS - 1)) begin
                        state_d = ST_COMMIT;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end else begin
                    gr_d = gr_q + 3'd1;
                end
            end

            ST_COMMIT: begin
                fb_d    = bb_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and visible outputs; reset aborts any job in flight.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fb_q    <= fb_d;
        end
    end

    // Job context and back buffer are always reinitialised before use.
    always_ff @(posedge clock_i) begin
        row_q     <= row_d;
        ch_q      <= ch_d;
        gr_q      <= gr_d;
        letters_q <= letters_d;
        ypos_q    <= ypos_d;
        en_q      <= en_d;
        bb_q      <= bb_d;
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign framebuffer_o = fb_q;

endmodule
